// File: rtl/spi_byte_master.sv
// Single-byte SPI master: shifts one byte out on MOSI/SCLK and captures one
// byte from MISO per transaction. CPOL, CPHA and bit order are latched with
// start so upstream may change them freely while a byte is in flight.
module spi_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] D_in,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       MSBfirst,
  input  logic       MISO,
  output logic       busy,
  output logic       done,
  output logic [7:0] D_out,
  output logic       MOSI,
  output logic       SCLK
);

  // Half SCLK period in system clocks; the counter needs at least one bit
  // even when H is 1 (CLK_DIV of 2).
  localparam int H = CLK_DIV / 2;
  localparam int HC_W = (H > 1) ? $clog2(H) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(H - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state;
  logic [HC_W-1:0] hc;
  logic [3:0]      edge_cnt;
  logic [7:0]      tx_q;
  logic [7:0]      rx_q;
  logic            cpol_q;
  logic            cpha_q;
  logic            msb_q;

  logic            hc_wrap;
  logic            sample_now;
  logic            mosi_shift;
  logic [2:0]      tx_idx;
  logic [7:0]      rx_next;

  // Bit k of a byte in transmission order: k=0 is the first bit on the wire.
  function automatic logic bit_of(input logic [7:0] data_v,
                                  input logic       msb_v,
                                  input logic [2:0] idx);
    return msb_v ? data_v[3'd7 - idx] : data_v[idx];
  endfunction

  // Edge scheduling: the clock with hc at its last value toggles SCLK, and
  // in that same clock MISO is sampled and MOSI moves on as the mode dictates.
  // CPHA=0 samples on leading (even) edges and shifts on trailing edges 1..13;
  // CPHA=1 shifts on leading edges (bit k at edge 2k) and samples on trailing.
  always_comb begin
    hc_wrap    = (state == ST_SHIFT) && (hc == HC_LAST);
    sample_now = hc_wrap && (cpha_q ? edge_cnt[0] : ~edge_cnt[0]);
    if (cpha_q) begin
      mosi_shift = hc_wrap && ~edge_cnt[0];
      tx_idx     = edge_cnt[3:1];
    end else begin
      mosi_shift = hc_wrap && edge_cnt[0] && (edge_cnt != 4'd15);
      tx_idx     = edge_cnt[3:1] + 3'd1;
    end
    rx_next = rx_q;
    if (sample_now) begin
      if (msb_q) begin
        rx_next = {rx_q[6:0], MISO};
      end else begin
        rx_next = {MISO, rx_q[7:1]};
      end
    end
  end

  // Main sequencer: IDLE waits for start and tracks CPOL on SCLK, SHIFT runs
  // sixteen SCLK half-periods, DONE pulses done for a single clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hc       <= '0;
      edge_cnt <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      msb_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      D_out    <= '0;
      MOSI     <= 1'b0;
      SCLK     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          SCLK <= CPOL;
          done <= 1'b0;
          if (start) begin
            tx_q     <= D_in;
            cpol_q   <= CPOL;
            cpha_q   <= CPHA;
            msb_q    <= MSBfirst;
            hc       <= '0;
            edge_cnt <= '0;
            rx_q     <= '0;
            busy     <= 1'b1;
            state    <= ST_SHIFT;
            if (!CPHA) begin
              MOSI <= bit_of(D_in, MSBfirst, 3'd0);
            end
          end
        end

        ST_SHIFT: begin
          rx_q <= rx_next;
          if (hc_wrap) begin
            hc       <= '0;
            SCLK     <= ~SCLK;
            edge_cnt <= edge_cnt + 4'd1;
            if (mosi_shift) begin
              MOSI <= bit_of(tx_q, msb_q, tx_idx);
            end
            if (edge_cnt == 4'd15) begin
              state <= ST_DONE;
              done  <= 1'b1;
              D_out <= rx_next;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master. Two instances (CLK_DIV 4 and 2)
// share all inputs; each gets its own MISO from a slave model or loopback.
module tb_spi_byte_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] D_in;
  logic       CPOL;
  logic       CPHA;
  logic       MSBfirst;
  logic       loop_mode;
  logic       slave_bit [2];

  logic       miso4, busy4, done4, mosi4, sclk4;
  logic [7:0] dout4;
  logic       miso2, busy2, done2, mosi2, sclk2;
  logic [7:0] dout2;

  int assert_count = 0;
  int fail_count   = 0;

  logic [7:0] wire_seq  [2];
  int         edge_cnt  [2];
  logic       prev_sclk [2];

  typedef struct {
    logic [7:0] din;
    logic       cpol;
    logic       cpha;
    logic       msb;
    logic [7:0] slave_byte;
    logic       loop;
    logic [7:0] exp_dout;
  } vec_t;

  assign miso4 = loop_mode ? mosi4 : slave_bit[0];
  assign miso2 = loop_mode ? mosi2 : slave_bit[1];

  spi_byte_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .D_in(D_in), .CPOL(CPOL),
    .CPHA(CPHA), .MSBfirst(MSBfirst), .MISO(miso4), .busy(busy4),
    .done(done4), .D_out(dout4), .MOSI(mosi4), .SCLK(sclk4)
  );

  spi_byte_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .D_in(D_in), .CPOL(CPOL),
    .CPHA(CPHA), .MSBfirst(MSBfirst), .MISO(miso2), .busy(busy2),
    .done(done2), .D_out(dout2), .MOSI(mosi2), .SCLK(sclk2)
  );

  // Free-running system clock, period 10.
  always #5 clk = ~clk;

  function automatic logic order_bit(input logic [7:0] b, input logic msb, input int k);
    return msb ? b[7-k] : b[k];
  endfunction

  function automatic logic [7:0] bit_reverse(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Per-cycle check of one instance against the protocol rules: busy/done
  // windows, edge timing, wire bit order, slave-driven MISO and final byte.
  task automatic observeDut(input int d, input int c, input vec_t v);
    int div, h, last, n;
    logic s, m, b, dn;
    logic [7:0] dout;
    div  = (d == 0) ? 4 : 2;
    h    = div / 2;
    last = 8 * div + 1;
    if (d == 0) begin
      s = sclk4; m = mosi4; b = busy4; dn = done4; dout = dout4;
    end else begin
      s = sclk2; m = mosi2; b = busy2; dn = done2; dout = dout2;
    end
    checkOutput($sformatf("busy div%0d c%0d", div, c), b, (c >= 1 && c <= last));
    checkOutput($sformatf("done div%0d c%0d", div, c), dn, (c == last));
    if (c >= 1 && c <= last && s !== prev_sclk[d]) begin
      n = edge_cnt[d];
      checkOutput($sformatf("edge%0d time div%0d", n, div), c, h * (n + 1) + 1);
      if (((n % 2) == 0) == (v.cpha == 1'b0)) wire_seq[d] = {wire_seq[d][6:0], m};
      if (v.cpha == 1'b0 && (n % 2) == 1 && (n + 1) / 2 < 8)
        slave_bit[d] = order_bit(v.slave_byte, v.msb, (n + 1) / 2);
      if (v.cpha == 1'b1 && (n % 2) == 0)
        slave_bit[d] = order_bit(v.slave_byte, v.msb, n / 2);
      edge_cnt[d]++;
    end
    prev_sclk[d] = s;
    if (c == last) begin
      checkOutput($sformatf("dout div%0d", div), dout, v.exp_dout);
      checkOutput($sformatf("sclk done div%0d", div), s, v.cpol);
      checkOutput($sformatf("edges div%0d", div), edge_cnt[d], 16);
      checkOutput($sformatf("wire div%0d", div), wire_seq[d],
                  v.msb ? v.din : bit_reverse(v.din));
    end
  endtask

  // Reset, settle SCLK to the chosen CPOL, issue one start and follow the
  // byte on both instances; the latched controls are disturbed mid-byte.
  task automatic applyStimulus(input vec_t v);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    D_in = v.din; CPOL = v.cpol; CPHA = v.cpha; MSBfirst = v.msb;
    loop_mode = v.loop;
    for (int d = 0; d < 2; d++)
      slave_bit[d] = v.cpha ? 1'b0 : order_bit(v.slave_byte, v.msb, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("idle sclk4", sclk4, v.cpol);
    checkOutput("idle sclk2", sclk2, v.cpol);
    checkOutput("idle busy4", busy4, 1'b0);
    for (int d = 0; d < 2; d++) begin
      edge_cnt[d] = 0; wire_seq[d] = 8'h00;
    end
    prev_sclk[0] = sclk4;
    prev_sclk[1] = sclk2;
    start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        D_in = ~v.din; CPOL = ~v.cpol; CPHA = ~v.cpha; MSBfirst = ~v.msb;
      end
      if (c == 12) begin
        D_in = v.din; CPOL = v.cpol; CPHA = v.cpha; MSBfirst = v.msb;
      end
      observeDut(0, c, v);
      observeDut(1, c, v);
    end
  endtask

  vec_t table_v [6];
  vec_t v;
  logic [7:0] b2b_bytes [3];
  logic [7:0] wire4;
  logic       prev4;
  int         done_cnt;

  initial begin
    rst = 1'b1; start = 1'b0; D_in = 8'h00; CPOL = 1'b0; CPHA = 1'b0;
    MSBfirst = 1'b1; loop_mode = 1'b1; slave_bit[0] = 1'b0; slave_bit[1] = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset busy4", busy4, 1'b0);
    checkOutput("reset done4", done4, 1'b0);
    checkOutput("reset dout4", dout4, 8'h00);
    checkOutput("reset mosi4", mosi4, 1'b0);
    checkOutput("reset sclk4", sclk4, 1'b0);

    table_v[0] = '{din: 8'hA5, cpol: 0, cpha: 0, msb: 1, slave_byte: 8'h00, loop: 1, exp_dout: 8'hA5};
    table_v[1] = '{din: 8'h01, cpol: 1, cpha: 1, msb: 0, slave_byte: 8'hFF, loop: 0, exp_dout: 8'hFF};
    table_v[2] = '{din: 8'h3C, cpol: 0, cpha: 1, msb: 1, slave_byte: 8'h00, loop: 1, exp_dout: 8'h3C};
    table_v[3] = '{din: 8'hC3, cpol: 1, cpha: 0, msb: 0, slave_byte: 8'h96, loop: 0, exp_dout: 8'h96};
    table_v[4] = '{din: 8'h80, cpol: 0, cpha: 0, msb: 0, slave_byte: 8'h01, loop: 0, exp_dout: 8'h01};
    table_v[5] = '{din: 8'h7E, cpol: 1, cpha: 1, msb: 1, slave_byte: 8'h00, loop: 1, exp_dout: 8'h7E};
    for (int i = 0; i < 6; i++) applyStimulus(table_v[i]);

    // Random bytes and modes; the received byte must be whatever the far
    // end sent, in the agreed bit order.
    for (int i = 0; i < 10; i++) begin
      v.din        = 8'($urandom_range(0, 255));
      v.cpol       = 1'($urandom_range(0, 1));
      v.cpha       = 1'($urandom_range(0, 1));
      v.msb        = 1'($urandom_range(0, 1));
      v.slave_byte = 8'($urandom_range(0, 255));
      v.loop       = 1'($urandom_range(0, 1));
      v.exp_dout   = v.loop ? v.din : v.slave_byte;
      applyStimulus(v);
    end

    // Back-to-back bytes with start held high; D_in advances on each done.
    b2b_bytes[0] = 8'h00; b2b_bytes[1] = 8'h10; b2b_bytes[2] = 8'h40;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; MSBfirst = 1'b1; loop_mode = 1'b1; D_in = b2b_bytes[0];
    @(posedge clk); #1; @(posedge clk); #1;
    start = 1'b1; done_cnt = 0; wire4 = 8'h00; prev4 = sclk4;
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk); #1;
      if (prev4 == 1'b0 && sclk4 == 1'b1) wire4 = {wire4[6:0], mosi4};
      prev4 = sclk4;
      if (c % 34 == 0) checkOutput($sformatf("b2b busy c%0d", c), busy4, 1'b0);
      if (done4) begin
        if (done_cnt < 3) begin
          checkOutput($sformatf("b2b done cycle %0d", done_cnt), c, 34 * done_cnt + 33);
          checkOutput($sformatf("b2b wire %0d", done_cnt), wire4, b2b_bytes[done_cnt]);
          checkOutput($sformatf("b2b dout %0d", done_cnt), dout4, b2b_bytes[done_cnt]);
        end
        done_cnt++;
        wire4 = 8'h00;
        if (done_cnt < 3) D_in = b2b_bytes[done_cnt];
        else start = 1'b0;
      end
    end
    checkOutput("b2b done count", done_cnt, 3);

    // A start pulse in the middle of a byte must be ignored.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    D_in = 8'h5A; CPOL = 1'b0; CPHA = 1'b0; MSBfirst = 1'b1; loop_mode = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      checkOutput($sformatf("pulse done4 c%0d", c), done4, (c == 33));
      checkOutput($sformatf("pulse busy4 c%0d", c), busy4, (c <= 33));
      checkOutput($sformatf("pulse done2 c%0d", c), done2, (c == 17));
      if (c == 33) checkOutput("pulse dout4", dout4, 8'h5A);
    end

    // Reset in the middle of a byte: outputs clear, no done, D_out is 0.
    D_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 14) checkOutput("pre-reset mosi4", mosi4, 1'b1);
      if (c == 15) rst = 1'b1;
      if (c == 16) begin
        rst = 1'b0;
        checkOutput("abort sclk4", sclk4, 1'b0);
        checkOutput("abort mosi4", mosi4, 1'b0);
        checkOutput("abort busy4", busy4, 1'b0);
        checkOutput("abort dout4", dout4, 8'h00);
        checkOutput("abort busy2", busy2, 1'b0);
        checkOutput("abort dout2", dout2, 8'h00);
      end
      if (c >= 15) begin
        checkOutput($sformatf("abort done4 c%0d", c), done4, 1'b0);
        checkOutput($sformatf("abort done2 c%0d", c), done2, 1'b0);
      end
    end

    // A normal byte after the aborted one.
    applyStimulus(table_v[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
